// File: rtl/perf_counter_bank.sv
// Performance-monitor counter bank: one cycle counter plus NUM_EVT event counters with a registered read port.
// Optional shadow snapshot set is built when PERF_SNAPSHOT_EN is defined.
module perf_counter_bank #(
  parameter int unsigned NUM_EVT  = 4,
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b0,
  localparam int unsigned AW      = $clog2(NUM_EVT + 2)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_count_en,
  input  logic               i_clr,
  input  logic [NUM_EVT-1:0] i_evt,
  input  logic               i_snap,
  input  logic               i_rd_shadow,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [CNT_W-1:0]   o_rd_data,
  output logic [NUM_EVT:0]   o_ovf
);

  localparam int unsigned NC = NUM_EVT + 1;

  logic [NC-1:0]    w_inc;
  logic [CNT_W-1:0] r_cnt [NC];
  logic [NC-1:0]    r_ovf;
  logic [CNT_W-1:0] r_rd_data;
  logic [CNT_W-1:0] w_rd_val;

  // Index 0 is the cycle counter, index i+1 tracks evt[i].
  assign w_inc = i_count_en ? {i_evt, 1'b1} : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NC; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else if (i_clr) begin
      for (int unsigned i = 0; i < NC; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < NC; i++) begin
        if (w_inc[i]) begin
          if (&r_cnt[i]) begin
            r_ovf[i] <= 1'b1;
            if (!SATURATE) r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] r_shd [NC];

  // Shadow copy takes the pre-update live values, so snap+clr reads back the cleared totals.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NC; i++) r_shd[i] <= '0;
    end else if (i_snap) begin
      for (int unsigned i = 0; i < NC; i++) r_shd[i] <= r_cnt[i];
    end
  end
`else
  logic w_unused_snap;
  assign w_unused_snap = i_snap ^ i_rd_shadow;
`endif

  // Read mux: counters, then status word, anything beyond returns zero.
  always_comb begin
    w_rd_val = '0;
    if (i_rd_addr == AW'(NC)) w_rd_val = CNT_W'(r_ovf);
    for (int unsigned i = 0; i < NC; i++) begin
      if (i_rd_addr == AW'(i)) begin
`ifdef PERF_SNAPSHOT_EN
        w_rd_val = i_rd_shadow ? r_shd[i] : r_cnt[i];
`else
        w_rd_val = r_cnt[i];
`endif
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rd_data <= '0;
    else       r_rd_data <= w_rd_val;
  end

  assign o_rd_data = r_rd_data;
  assign o_ovf     = r_ovf;

endmodule
